ps2_transmitter: RTL and testbench
==================================

Name: ps2_transmitter

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard over the shared open-drain ps2_clk/ps2_data lines.
- Runs in the system clock domain. Samples the device clock through a synchronizer; drives both lines only via active-high pull-low enables.
- Sits beside the keyboard receiver. Asserts rx_block so the receiver's bit count can be gated while the host owns the bus.

Parameters:
INHIBIT_CYCLES, 5000, clk cycles ps2_clk is held low before the start bit (100 us at 50 MHz)
TIMEOUT_CYCLES, 1000000, max clk cycles from clock release to end of ACK phase (20 ms at 50 MHz)

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-low
tx_data  input  8  command byte; sampled on accept
tx_valid  input  1  request to send tx_data
tx_ready  output  1  high only in IDLE; accept = tx_valid && tx_ready at a rising clk edge
tx_done  output  1  one-cycle pulse: byte sent and device ACKed, bus idle again
tx_error  output  1  one-cycle pulse: NACK or timeout
rx_block  output  1  high from accept until return to IDLE
ps2_clk_in  input  1  raw PS/2 clock pin level
ps2_data_in  input  1  raw PS/2 data pin level
ps2_clk_oe  output  1  1 = pull ps2_clk low; 0 = release
ps2_data_oe  output  1  1 = pull ps2_data low; 0 = release

Behaviour:
- Synchronizer
  - ps2_clk_in and ps2_data_in each pass through 2 FFs, reset to 1.
  - fall = previous synced clk 1 AND current synced clk 0. Detection latency is 2-3 clk cycles.
- Reset (rst low, async): state IDLE, tx_ready 1 (decoded from state), tx_done 0, tx_error 0, rx_block 0, ps2_clk_oe 0, ps2_data_oe 0, all counters 0.
  - Reset mid-operation releases both lines immediately.
  - No done or error pulse is generated for an aborted transfer.
- Frame register: accept loads shreg[9:0] = {1'b1 stop, ~^tx_data odd parity, tx_data}. LSB is shifted out first.
- States:
  - IDLE:
    - clk_oe=0, data_oe=0, rx_block=0.
    - On accept: go to INHIBIT, cnt=0, clk_oe=1, rx_block=1.
  - INHIBIT:
    - clk_oe=1; cnt increments each cycle.
    - At cnt==INHIBIT_CYCLES-1: data_oe=1 (start bit), go to RELEASE.
  - RELEASE:
    - One cycle with clk_oe=1, data_oe=1. Then clk_oe=0.
    - Go to SHIFT with bit_cnt=0 and watchdog=0.
  - SHIFT:
    - On each fall: data_oe = ~shreg[0], shift shreg right, bit_cnt++.
    - The 10th fall drives the stop bit (data_oe=0), then go to ACK.
  - ACK:
    - On the next fall, sample synced data.
    - 0: go to WAIT_IDLE.
    - 1: tx_error pulse, go to IDLE.
  - WAIT_IDLE: when synced clk==1 and synced data==1, pulse tx_done and go to IDLE.
- Watchdog:
  - Counts every cycle in SHIFT, ACK and WAIT_IDLE. It is not cleared by falls.
  - On reaching TIMEOUT_CYCLES-1: release both lines, pulse tx_error, go to IDLE.
  - Timeout has priority over a same-cycle fall or ACK sample.
- Counter widths: $clog2 of the respective parameter, minimum 1 bit.
- tx_valid outside IDLE is ignored and tx_data is not re-sampled.
  - A new accept is possible on the cycle after the tx_done or tx_error pulse.
- tx_done and tx_error are never high in the same cycle.
- data_oe changes only on a detected fall or on the entry/exit transitions above. clk_oe is high only in INHIBIT and RELEASE.

Test Plan:
- Send 0xED with a device model clocking at 12.5 kHz, ACK low on the 11th fall.
  - Device samples on rising edges: start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - Then tx_done pulses once and rx_block drops.
- Parity: send 0x01 and 0x00.
  - 0x01 gives parity 0; 0x00 gives parity 1.
  - ps2_clk_oe is high for exactly INHIBIT_CYCLES+1 cycles.
- NACK: device leaves data high on the 11th fall.
  - tx_error pulses once, tx_done stays 0, both oe are 0, tx_ready is 1 next cycle.
- Timeout: device never clocks.
  - tx_error pulses exactly TIMEOUT_CYCLES cycles after entering SHIFT; lines are released.
- Reset mid-frame: assert rst after the 4th fall.
  - Both oe go to 0 asynchronously; no pulses; tx_ready=1.
  - After release, a full 0xFF send succeeds.
- Backpressure: hold tx_valid high with tx_data changing during a transfer.
  - Only the byte present at accept is sent.
  - The second accept occurs exactly one cycle after tx_done.

Source files
------------

// File: rtl/ps2_transmitter.sv
// Host-to-device PS/2 command transmitter: inhibits the bus, issues a start bit,
// shifts out an 11-bit frame on device clock falls and checks the device ACK.
module ps2_transmitter #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       rx_block,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    RELEASE   = 3'd2,
    SHIFT     = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  state_t           state_r, state_s;
  logic [1:0]       clk_sync_r, data_sync_r;
  logic             clk_prev_r;
  logic [9:0]       shreg_r, shreg_s;
  logic [3:0]       bit_cnt_r, bit_cnt_s;
  logic [INH_W-1:0] inh_cnt_r, inh_cnt_s;
  logic [TO_W-1:0]  wdog_r, wdog_s;
  logic             clk_oe_r, clk_oe_s, data_oe_r, data_oe_s;
  logic             rx_block_r, rx_block_s, done_r, done_s, error_r, error_s;
  logic             fall_s, timeout_s;

  // Two-flop synchronizers on both bus lines plus the edge-detect history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_r  <= 2'b11;
      data_sync_r <= 2'b11;
      clk_prev_r  <= 1'b1;
    end else begin
      clk_sync_r  <= {clk_sync_r[0], ps2_clk_in};
      data_sync_r <= {data_sync_r[0], ps2_data_in};
      clk_prev_r  <= clk_sync_r[1];
    end
  end

  assign fall_s    = clk_prev_r & ~clk_sync_r[1];
  assign timeout_s = (wdog_r == TO_LAST);

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_s    = state_r;
    shreg_s    = shreg_r;
    bit_cnt_s  = bit_cnt_r;
    inh_cnt_s  = inh_cnt_r;
    wdog_s     = wdog_r;
    clk_oe_s   = clk_oe_r;
    data_oe_s  = data_oe_r;
    rx_block_s = rx_block_r;
    done_s     = 1'b0;
    error_s    = 1'b0;
    case (state_r)
      IDLE: begin
        clk_oe_s   = 1'b0;
        data_oe_s  = 1'b0;
        rx_block_s = 1'b0;
        if (tx_valid) begin
          state_s    = INHIBIT;
          inh_cnt_s  = {INH_W{1'b0}};
          clk_oe_s   = 1'b1;
          rx_block_s = 1'b1;
          shreg_s    = {1'b1, odd_parity(tx_data), tx_data};
        end else begin
          state_s = IDLE;
        end
      end
      INHIBIT: begin
        clk_oe_s  = 1'b1;
        inh_cnt_s = inh_cnt_r + INH_W'(1);
        if (inh_cnt_r == INH_LAST) begin
          data_oe_s = 1'b1;
          state_s   = RELEASE;
        end else begin
          state_s = INHIBIT;
        end
      end
      RELEASE: begin
        clk_oe_s  = 1'b0;
        state_s   = SHIFT;
        bit_cnt_s = 4'd0;
        wdog_s    = {TO_W{1'b0}};
      end
      SHIFT, ACK, WAIT_IDLE: begin
        wdog_s = wdog_r + TO_W'(1);
        // Watchdog wins over any same-cycle fall or ACK sample
        if (timeout_s) begin
          clk_oe_s   = 1'b0;
          data_oe_s  = 1'b0;
          rx_block_s = 1'b0;
          error_s    = 1'b1;
          state_s    = IDLE;
        end else if (state_r == SHIFT) begin
          if (fall_s) begin
            data_oe_s = ~shreg_r[0];
            shreg_s   = {1'b1, shreg_r[9:1]};
            bit_cnt_s = bit_cnt_r + 4'd1;
            if (bit_cnt_r == 4'd9) begin
              state_s = ACK;
            end else begin
              state_s = SHIFT;
            end
          end else begin
            state_s = SHIFT;
          end
        end else if (state_r == ACK) begin
          if (fall_s && !data_sync_r[1]) begin
            state_s = WAIT_IDLE;
          end else if (fall_s) begin
            data_oe_s  = 1'b0;
            rx_block_s = 1'b0;
            error_s    = 1'b1;
            state_s    = IDLE;
          end else begin
            state_s = ACK;
          end
        end else begin
          if (clk_sync_r[1] && data_sync_r[1]) begin
            rx_block_s = 1'b0;
            done_s     = 1'b1;
            state_s    = IDLE;
          end else begin
            state_s = WAIT_IDLE;
          end
        end
      end
      default: begin
        state_s    = IDLE;
        clk_oe_s   = 1'b0;
        data_oe_s  = 1'b0;
        rx_block_s = 1'b0;
      end
    endcase
  end

  // State, counters and output registers; reset releases both lines at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      shreg_r    <= 10'd0;
      bit_cnt_r  <= 4'd0;
      inh_cnt_r  <= {INH_W{1'b0}};
      wdog_r     <= {TO_W{1'b0}};
      clk_oe_r   <= 1'b0;
      data_oe_r  <= 1'b0;
      rx_block_r <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      shreg_r    <= shreg_s;
      bit_cnt_r  <= bit_cnt_s;
      inh_cnt_r  <= inh_cnt_s;
      wdog_r     <= wdog_s;
      clk_oe_r   <= clk_oe_s;
      data_oe_r  <= data_oe_s;
      rx_block_r <= rx_block_s;
      done_r     <= done_s;
      error_r    <= error_s;
    end
  end

  assign tx_ready    = (state_r == IDLE);
  assign tx_done     = done_r;
  assign tx_error    = error_r;
  assign rx_block    = rx_block_r;
  assign ps2_clk_oe  = clk_oe_r;
  assign ps2_data_oe = data_oe_r;

endmodule

// File: tb/tb_ps2_transmitter.sv
// Directed bench for ps2_transmitter with an open-drain bus and a simple
// keyboard model that samples data on rising clock edges.
module tb_ps2_transmitter;
  localparam int INH = 20;
  localparam int TO  = 2000;
  localparam int H   = 20;

  logic       clk, rst, tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, tx_done, tx_error, rx_block;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low, dev_data_low;
  logic       clk_line, data_line;
  int         passed, total;
  int         done_cnt, err_cnt, both_cnt, oe_run, last_run;

  assign clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign data_line = ~(ps2_data_oe | dev_data_low);

  ps2_transmitter #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_done(tx_done), .tx_error(tx_error),
    .rx_block(rx_block), .ps2_clk_in(clk_line), .ps2_data_in(data_line),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters and clock-inhibit run length
  always @(negedge clk) begin
    if (tx_done) done_cnt++;
    if (tx_error) err_cnt++;
    if (tx_done && tx_error) both_cnt++;
    if (ps2_clk_oe) oe_run++;
    else if (oe_run != 0) begin last_run = oe_run; oe_run = 0; end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic start_tx(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  // Keyboard model: bits[0]=start, [8:1]=byte, [9]=parity, [10]=stop
  task automatic dev_frame(input int nfalls, input bit ack, output logic [10:0] bits);
    int t;
    bits = 11'h7FF;
    t = 0;
    while (ps2_clk_oe !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    t = 0;
    while (ps2_clk_oe !== 1'b0 && t < 200) begin @(negedge clk); t++; end
    repeat (2) @(negedge clk);
    bits[0] = data_line;
    for (int i = 1; i <= 10; i++) begin
      repeat (H) @(negedge clk);
      dev_clk_low = 1'b1;
      if (i == nfalls) return;
      repeat (H) @(negedge clk);
      dev_clk_low = 1'b0;
      bits[i] = data_line;
    end
    repeat (H / 2) @(negedge clk);
    if (ack) dev_data_low = 1'b1;
    repeat (H / 2) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (H) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (2) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_end(input int d0, input int e0);
    int t;
    t = 0;
    while (done_cnt == d0 && err_cnt == e0 && t < 3000) begin @(negedge clk); t++; end
    repeat (2) @(negedge clk);
  endtask

  task automatic send_ok(input string tag, input logic [7:0] d, input logic par);
    logic [10:0] b;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    start_tx(d);
    dev_frame(11, 1'b1, b);
    wait_end(d0, e0);
    chk({tag, "_start"}, b[0], 1'b0);
    chk({tag, "_byte"}, b[8:1], d);
    chk({tag, "_parity"}, b[9], par);
    chk({tag, "_stop"}, b[10], 1'b1);
    chk({tag, "_done"}, done_cnt - d0, 1);
    chk({tag, "_noerr"}, err_cnt - e0, 0);
    chk({tag, "_oe_run"}, last_run, INH + 1);
    chk({tag, "_rx_block"}, rx_block, 1'b0);
  endtask

  initial begin
    logic [10:0] b;
    int d0, e0, n, t;
    passed = 0; total = 0;
    done_cnt = 0; err_cnt = 0; both_cnt = 0; oe_run = 0; last_run = 0;
    dev_clk_low = 1'b0; dev_data_low = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00; rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", tx_ready, 1'b1);
    chk("rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    chk("rst_flags", {tx_done, tx_error, rx_block}, 3'b000);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    send_ok("ed", 8'hED, 1'b1);
    send_ok("p01", 8'h01, 1'b0);
    send_ok("p00", 8'h00, 1'b1);

    // NACK: data left high on the 11th fall
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'h12);
    dev_frame(11, 1'b0, b);
    wait_end(d0, e0);
    chk("nack_byte", b[8:1], 8'h12);
    chk("nack_err", err_cnt - e0, 1);
    chk("nack_nodone", done_cnt - d0, 0);
    chk("nack_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    chk("nack_ready", tx_ready, 1'b1);

    // Timeout: device never clocks
    e0 = err_cnt;
    start_tx(8'hFF);
    t = 0;
    while (ps2_clk_oe !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    t = 0;
    while (ps2_clk_oe !== 1'b0 && t < 200) begin @(negedge clk); t++; end
    n = 0;
    while (tx_error !== 1'b1 && n < TO + 50) begin @(negedge clk); n++; end
    chk("to_cycles", n, TO);
    chk("to_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    repeat (2) @(negedge clk);
    chk("to_err", err_cnt - e0, 1);

    // Reset after the 4th fall while sending 0x00 (bit 3 pulls data low)
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'h00);
    dev_frame(4, 1'b1, b);
    repeat (5) @(negedge clk);
    chk("mid_data_oe", ps2_data_oe, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    chk("mid_rst_ready", tx_ready, 1'b1);
    repeat (3) @(negedge clk);
    dev_clk_low = 1'b0;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_no_pulse", {done_cnt - d0, err_cnt - e0}, 64'd0);
    send_ok("ff", 8'hFF, 1'b1);

    // Backpressure: valid held, data changed after accept
    @(negedge clk);
    tx_data = 8'h5A; tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_data = 8'hA5;
    dev_frame(11, 1'b1, b);
    chk("bp_byte1", b[8:1], 8'h5A);
    t = 0;
    while (tx_done !== 1'b1 && t < 3000) begin @(negedge clk); t++; end
    chk("bp_done_seen", tx_done, 1'b1);
    chk("bp_ready_at_done", tx_ready, 1'b1);
    @(negedge clk);
    chk("bp_accept_next", {rx_block, tx_ready, tx_done}, 3'b100);
    tx_valid = 1'b0;
    d0 = done_cnt; e0 = err_cnt;
    dev_frame(11, 1'b1, b);
    wait_end(d0, e0);
    chk("bp_byte2", b[8:1], 8'hA5);
    chk("bp_parity2", b[9], 1'b1);
    chk("bp_done2", done_cnt - d0, 1);
    chk("never_both", both_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
